filt_sched: RTL and testbench
=============================

// Module: filt_sched
// PURPOSE
// Sample scheduler in front of the filters block. Queues ADC samples in a small FIFO and latches the
// filter select per sample. Drives the filters start/done handshake one sample at a time and returns
// each filtered result as a one-cycle valid strobe. Flags overruns (FIFO full) and hung filters (timeout).
// PARAMETERS
// DATA_SIZE      16   sample/result width (matches XADC_DATA_SIZE)
// FIFO_DEPTH     4    sample FIFO entries, power of two
// FIFO_ADDR_SIZE 2    log2(FIFO_DEPTH)
// TO_SIZE        8    timeout counter width
// TO_CYCLES      200  max cycles in RUN before abort, < 2**TO_SIZE
// PORTS
// clk         in  1          single clock; one clock, reset synchronous active-high
// rst         in  1          synchronous active-high reset
// smp_valid   in  1          new ADC sample strobe
// smp_data    in  DATA_SIZE  ADC sample
// sel_req     in  2          requested filter: 00 LPF, 01 HPF, 10 BPF, 11 bypass
// clr_flags   in  1          clears overrun, timeout, drop_cnt
// flt_start   out 1          to filters.start (level)
// flt_select  out 2          to filters.filt_select, stable for whole run
// flt_val     out DATA_SIZE  to filters.val, stable for whole run
// flt_done    in  1          from filters.done
// flt_result  in  DATA_SIZE  from filters.result (registered in filters on done)
// out_valid   out 1          one-cycle result strobe
// out_data    out DATA_SIZE  filtered sample, held until next out_valid
// out_sel     out 2          filter that produced out_data
// busy        out 1          FSM not in IDLE or FIFO not empty
// overrun     out 1          sticky: sample dropped
// timeout     out 1          sticky: run aborted
// drop_cnt    out 8          saturating dropped-sample count
// BEHAVIOUR
// - Reset: all outputs 0. FSM goes to IDLE, FIFO is emptied, timeout counter is 0.
//   Reset mid-run takes effect at the next edge: flt_start is 0 after that edge.
// - FIFO push on smp_valid.
//   - Full with no pop the same cycle: newest sample dropped, overrun<=1, drop_cnt+1 saturating at 255.
//   - Full with a pop the same cycle: push accepted.
//   - Pointers wrap modulo FIFO_DEPTH.
// - FSM IDLE->LOAD->RUN->CAPT->GAP->IDLE.
//   - IDLE: if FIFO not empty, go to LOAD.
//   - LOAD: pop the head into flt_val; flt_select<=sel_req; clear the timeout counter.
//     sel_req is sampled only here, so a change during a run applies to the next sample.
//   - RUN: flt_start=1 (held, since filters needs start for >=2 cycles). The counter increments every cycle.
//     - flt_done=1 -> CAPT. Done is ignored outside RUN; bypass has done tied high.
//     - counter==TO_CYCLES with no done -> timeout<=1, GAP, no out_valid.
//   - CAPT: flt_start=0. out_data<=flt_result, out_sel<=flt_select, out_valid=1 for this cycle only.
//     flt_result is captured one cycle after done, because filters registers it on done.
//   - GAP: flt_start=0 for one cycle so filters re-arms -> IDLE.
// - Throughput: one sample per (run length + 4) cycles. Latency from LOAD entry to out_valid is
//   run length + 2. In bypass, out_valid comes 3 cycles after LOAD with out_data=smp.
// - clr_flags clears the flags the next cycle. A drop in the same cycle as clr_flags wins:
//   overrun=1, drop_cnt=1.
// - No arithmetic on data; all widths pass through unchanged.
// STRUCTURE
// - Shared header filt_defs.vh holds:
//   - FILT_SEL_LPF/HPF/BPF/BYP codes
//   - FSM state localparams S_IDLE=0, S_LOAD=1, S_RUN=2, S_CAPT=3, S_GAP=4
// - One sub-module: smp_fifo, a synchronous FIFO with push, pop, full, empty, dout.
// - FSM, timeout counter and flags live in filt_sched.
// TESTING
// 1. rst; one sample 0x1234, sel_req=11, flt_done tied 1, flt_result=0x1234
//    -> out_valid on cycle 3 after LOAD, out_data=0x1234, out_sel=11.
// 2. Filters model with done after 30 cycles, 3 samples back-to-back, sel=00
//    -> 3 out_valid in order, flt_start low >=1 cycle between runs.
// 3. 6 samples in consecutive cycles while the first run is still active, FIFO_DEPTH=4
//    -> 4 queued plus 1 in run; 1 dropped, overrun=1, drop_cnt=1.
// 4. flt_done never asserts -> timeout=1 after 200 RUN cycles, no out_valid, next sample still served.
// 5. sel_req toggles 00->01 mid-run -> flt_select stays 00 until done; next sample uses 01.
// 6. rst asserted during RUN -> next cycle flt_start=0, busy=0, flags 0; clr_flags clears sticky flags.

Source files
------------

// File: rtl/filt_sched_pkg.sv
// Shared definitions for the filter sample scheduler:
// filter select codes, FSM states and a saturating counter helper.
package filt_sched_pkg;

  localparam logic [1:0] FILT_SEL_LPF = 2'b00;
  localparam logic [1:0] FILT_SEL_HPF = 2'b01;
  localparam logic [1:0] FILT_SEL_BPF = 2'b10;
  localparam logic [1:0] FILT_SEL_BYP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/filt_sched_smp_fifo.sv
// Synchronous sample FIFO; push/pop are already qualified
// by the caller, so no overflow/underflow guarding here.
module filt_sched_smp_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // storage write, no reset needed on the data
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/filt_sched.sv
// Sample scheduler in front of the filters block: queues samples,
// runs one filter start/done handshake per sample, flags errors.
module filt_sched
  import filt_sched_pkg::*;
#(
  parameter int DATA_SIZE      = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_ADDR_SIZE = 2,
  parameter int TO_SIZE        = 8,
  parameter int TO_CYCLES      = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 smp_valid,
  input  logic [DATA_SIZE-1:0] smp_data,
  input  logic [1:0]           sel_req,
  input  logic                 clr_flags,
  output logic                 flt_start,
  output logic [1:0]           flt_select,
  output logic [DATA_SIZE-1:0] flt_val,
  input  logic                 flt_done,
  input  logic [DATA_SIZE-1:0] flt_result,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [1:0]           out_sel,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout,
  output logic [7:0]           drop_cnt
);

  state_t state;
  state_t state_nx;

  logic [TO_SIZE-1:0]   to_cnt;
  logic                 to_hit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_dout;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 capt;
  logic                 abort;

  // a pop in the same cycle frees a slot for the push
  assign drop   = smp_valid & fifo_full & ~pop;
  assign push   = smp_valid & ~drop;
  assign to_hit = (to_cnt == TO_SIZE'(TO_CYCLES));
  assign busy   = (state != S_IDLE) | ~fifo_empty;

  filt_sched_smp_fifo #(
    .W     (DATA_SIZE),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_ADDR_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (smp_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state; done wins over a same-cycle timeout
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (!fifo_empty) state_nx = S_LOAD;
      S_LOAD: state_nx = S_RUN;
      S_RUN: begin
        if (flt_done)    state_nx = S_CAPT;
        else if (to_hit) state_nx = S_GAP;
      end
      S_CAPT: state_nx = S_GAP;
      S_GAP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // per-state controls
  always_comb begin
    flt_start = 1'b0;
    pop       = 1'b0;
    capt      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      S_LOAD: pop = 1'b1;
      S_RUN: begin
        flt_start = 1'b1;
        abort     = ~flt_done & to_hit;
      end
      S_CAPT:  capt = 1'b1;
      default: ;
    endcase
  end

  // operands latched at load, held for the whole run
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_val    <= '0;
      flt_select <= '0;
    end else if (pop) begin
      flt_val    <= fifo_dout;
      flt_select <= sel_req;
    end
  end

  // run-length counter, restarted per sample
  always_ff @(posedge clk) begin
    if (rst)                  to_cnt <= '0;
    else if (state == S_LOAD) to_cnt <= '0;
    else if (state == S_RUN)  to_cnt <= to_cnt + 1'b1;
  end

  // result capture, one cycle after done
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      out_valid <= capt;
      if (capt) begin
        out_data <= flt_result;
        out_sel  <= flt_select;
      end
    end
  end

  // sticky flags; a new event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop) begin
        overrun  <= 1'b1;
        drop_cnt <= clr_flags ? 8'd1 : sat_inc8(drop_cnt);
      end else if (clr_flags) begin
        overrun  <= 1'b0;
        drop_cnt <= '0;
      end
      if (abort)          timeout <= 1'b1;
      else if (clr_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filt_sched.sv
// Bench for filt_sched: filters emulation, transaction-level
// reference model with per-cycle compare, directed + random stimulus.
module tb_filt_sched;
  import filt_sched_pkg::*;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = '0;
  logic [1:0]  sel_req = '0;
  logic        clr_flags = 1'b0;
  logic        flt_start;
  logic [1:0]  flt_select;
  logic [15:0] flt_val;
  logic        flt_done;
  logic [15:0] flt_result = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        busy;
  logic        overrun;
  logic        timeout;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  filt_sched dut (
    .clk        (clk),
    .rst        (rst),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .sel_req    (sel_req),
    .clr_flags  (clr_flags),
    .flt_start  (flt_start),
    .flt_select (flt_select),
    .flt_val    (flt_val),
    .flt_done   (flt_done),
    .flt_result (flt_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fres(
    input logic [15:0] v,
    input logic [1:0]  s
  );
    case (s)
      FILT_SEL_LPF: return v + 16'd1;
      FILT_SEL_HPF: return v ^ 16'hA5A5;
      FILT_SEL_BPF: return {v[7:0], v[15:8]};
      default:      return v;
    endcase
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // filters emulation: done after dly start cycles
  int dly = 1000;
  bit done_tied = 1'b0;
  int run_idx = 0;

  assign flt_done = done_tied |
    (flt_start && run_idx == dly - 1);

  always @(posedge clk) begin
    if (flt_start) run_idx <= run_idx + 1;
    else           run_idx <= 0;
    if (flt_done)  flt_result <= fres(flt_val, flt_select);
  end

  // result observer
  int nval = 0;
  logic [1:0] last_sel = '0;
  logic [1:0] prev_sel = '0;

  always @(negedge clk) begin
    if (out_valid) begin
      nval     <= nval + 1;
      last_sel <= out_sel;
      prev_sel <= last_sel;
    end
  end

  // reference model: age = cycles since sample load, -1 idle
  logic [15:0] q[$];
  int          age = -1;
  int          m_n = 1;
  bit          m_abt = 1'b0;
  logic [15:0] m_val = '0;
  logic [1:0]  m_sel = '0;
  bit          m_ov = 1'b0;
  bit          m_to = 1'b0;
  int          m_dc = 0;
  bit          m_ovl = 1'b0;
  logic [15:0] m_od = '0;
  logic [1:0]  m_os = '0;

  always @(negedge clk) begin
    bit act;
    bit pop;
    bit drp;
    bit idle_go;
    bit capt;
    bit abt;
    int cnt0;
    int last;
    act = (age >= 0);
    check("flt_start", flt_start,
          act && age >= 1 && age <= m_n);
    check("flt_select", flt_select, m_sel);
    check("flt_val", flt_val, m_val);
    check("out_valid", out_valid, m_ovl);
    check("out_data", out_data, m_od);
    check("out_sel", out_sel, m_os);
    check("busy", busy, act || q.size() != 0);
    check("overrun", overrun, m_ov);
    check("timeout", timeout, m_to);
    check("drop_cnt", drop_cnt, m_dc);
    if (rst) begin
      q.delete();
      age = -1;
      m_val = '0;
      m_sel = '0;
      m_ov = 1'b0;
      m_to = 1'b0;
      m_dc = 0;
      m_ovl = 1'b0;
      m_od = '0;
      m_os = '0;
    end else begin
      cnt0 = q.size();
      pop = act && age == 0;
      idle_go = !act && cnt0 != 0;
      capt = act && !m_abt && age == m_n + 1;
      abt = act && m_abt && age == m_n;
      drp = 1'b0;
      m_ovl = capt;
      if (capt) begin
        m_od = fres(m_val, m_sel);
        m_os = m_sel;
      end
      if (pop) begin
        m_val = q.pop_front();
        m_sel = sel_req;
      end
      if (smp_valid) begin
        if (cnt0 < 4 || pop) q.push_back(smp_data);
        else drp = 1'b1;
      end
      if (drp) begin
        m_ov = 1'b1;
        m_dc = clr_flags ? 1 : (m_dc < 255 ? m_dc + 1 : 255);
      end else if (clr_flags) begin
        m_ov = 1'b0;
        m_dc = 0;
      end
      if (abt) m_to = 1'b1;
      else if (clr_flags) m_to = 1'b0;
      if (act) begin
        last = m_abt ? m_n + 1 : m_n + 2;
        age++;
        if (age > last) age = -1;
      end else if (idle_go) begin
        age = 0;
        m_abt = !done_tied && dly > TO + 1;
        m_n = done_tied ? 1 : (dly <= TO + 1 ? dly : TO + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((age >= 0 || q.size() != 0) && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) begin
      total++;
      bad++;
      $display("FAIL idle_wait: busy after %0d cycles, want idle", g);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time %0t, want earlier finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;
    int n0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_start", flt_start, 0);
    check("rst_busy", busy, 0);
    check("rst_oval", out_valid, 0);
    check("rst_dc", drop_cnt, 0);
    tick();

    // bypass: done tied high, result = sample
    done_tied = 1'b1;
    sel_req   = FILT_SEL_BYP;
    smp_data  = 16'h1234;
    smp_valid = 1'b1;
    @(negedge clk);
    k = 0;
    tick();
    smp_valid = 1'b0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    check("byp_lat", k, 5);
    check("byp_data", out_data, 16'h1234);
    check("byp_sel", out_sel, 2'b11);
    tick();
    wait_idle();
    done_tied = 1'b0;

    // three back-to-back samples, 30-cycle filter
    dly = 30;
    sel_req = FILT_SEL_LPF;
    n0 = nval;
    smp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp_data = 16'(16'h0100 + i);
      tick();
    end
    smp_valid = 1'b0;
    wait_idle();
    check("b2b_cnt", nval - n0, 3);

    // six samples in a row: one dropped
    sel_req = FILT_SEL_BPF;
    n0 = nval;
    smp_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp_data = 16'(16'h0A00 + i);
      tick();
    end
    smp_valid = 1'b0;
    wait_idle();
    check("ovr_cnt", nval - n0, 5);
    check("ovr_flag", overrun, 1);
    check("ovr_dc", drop_cnt, 1);

    // hung filter, then a normal one
    dly = 1000;
    n0 = nval;
    send(16'h7777);
    wait_idle();
    check("to_flag", timeout, 1);
    check("to_nout", nval - n0, 0);
    dly = 10;
    send(16'h8888);
    wait_idle();
    check("to_next", nval - n0, 1);

    // clear flags
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    @(negedge clk);
    check("clr_ov", overrun, 0);
    check("clr_to", timeout, 0);
    check("clr_dc", drop_cnt, 0);
    tick();

    // drop coinciding with clear
    dly = 1000;
    smp_valid = 1'b1;
    repeat (6) tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    smp_valid = 1'b0;
    @(negedge clk);
    check("dclr_ov", overrun, 1);
    check("dclr_dc", drop_cnt, 1);
    tick();

    // saturate the drop counter
    smp_valid = 1'b1;
    repeat (600) tick();
    smp_valid = 1'b0;
    @(negedge clk);
    check("sat_dc", drop_cnt, 255);
    tick();

    // reset mid-run
    g = 0;
    while (!flt_start && g < 300) begin
      tick();
      g++;
    end
    check("mid_run", flt_start, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_start", flt_start, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ov", overrun, 0);
    check("mrst_to", timeout, 0);
    check("mrst_dc", drop_cnt, 0);
    tick();

    // done on the last allowed cycle vs one later
    dly = TO + 1;
    n0 = nval;
    send(16'h2011);
    wait_idle();
    check("edge_ok", nval - n0, 1);
    check("edge_to0", timeout, 0);
    dly = TO + 2;
    send(16'h2022);
    wait_idle();
    check("edge_nout", nval - n0, 1);
    check("edge_to1", timeout, 1);

    // select change mid-run applies to next sample
    dly = 20;
    sel_req = FILT_SEL_LPF;
    send(16'h0505);
    g = 0;
    while (!flt_start && g < 10) begin
      tick();
      g++;
    end
    repeat (5) tick();
    sel_req = FILT_SEL_HPF;
    send(16'h0606);
    wait_idle();
    check("sel_first", prev_sel, 0);
    check("sel_next", last_sel, 1);

    // random traffic
    for (int p = 0; p < 4; p++) begin
      dly = (p == 3) ? 1000 : int'($urandom_range(1, 40));
      for (int c = 0; c < 1500; c++) begin
        smp_valid = ($urandom_range(0, 5) == 0);
        smp_data  = 16'($urandom);
        sel_req   = 2'($urandom);
        clr_flags = ($urandom_range(0, 31) == 0);
        tick();
      end
      smp_valid = 1'b0;
      clr_flags = 1'b0;
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
